rv32_alu_issue: RTL and testbench

- Issue stage feeding the RV32I single-cycle ALU: accepts 32-bit OP/OP-IMM instruction words, reads the 32x32 register file and decodes funct3/funct7 into the ALU's 3-bit op_code.
- Presents registered op1/op2/op_code/rd to the ALU under a valid/ready handshake.
- Takes ALU results back as writeback; a per-register scoreboard blocks RAW/WAW hazards.

---
 rtl/rv32_alu_issue_if.sv | 31 +++
 rtl/rv32_alu_issue.sv | 196 +++++++++++++++++++
 tb/tb_rv32_alu_issue.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_alu_issue_if.sv
// Handshake bundle between the RV32I issue stage, its instruction source,
// the ALU and the writeback path.
interface rv32_alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic            alu_valid;
  logic            alu_ready;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [2:0]      alu_op_code;
  logic [4:0]      alu_rd;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  // Driver side: instruction source, ALU consumer and writeback producer.
  modport master (
    output instr_valid, instr, alu_ready, wb_valid, wb_rd, wb_data,
    input  instr_ready, alu_valid, alu_op1, alu_op2, alu_op_code, alu_rd, illegal
  );

  // Issue stage side.
  modport slave (
    input  instr_valid, instr, alu_ready, wb_valid, wb_rd, wb_data,
    output instr_ready, alu_valid, alu_op1, alu_op2, alu_op_code, alu_rd, illegal
  );
endinterface

// File: rtl/rv32_alu_issue.sv
// RV32I OP/OP-IMM issue stage: decode, register file read, scoreboard and
// registered ALU handoff. Define WB_BYPASS_EN to forward writeback data.
module rv32_alu_issue #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  rv32_alu_issue_if.slave io_bus
);

  localparam int unsigned RW    = 5;
  localparam int unsigned IMM_W = 12;
  localparam logic [6:0]  OPC_R  = 7'b0110011;
  localparam logic [6:0]  OPC_I  = 7'b0010011;
  localparam logic [6:0]  F7_ALT = 7'b0100000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Instruction fields
  logic [6:0]    w_opcode;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rs1;
  logic [RW-1:0] w_rs2;
  logic [2:0]    w_f3;
  logic [6:0]    w_f7;

  assign w_opcode = io_bus.instr[6:0];
  assign w_rd     = io_bus.instr[11:7];
  assign w_f3     = io_bus.instr[14:12];
  assign w_rs1    = io_bus.instr[19:15];
  assign w_rs2    = io_bus.instr[24:20];
  assign w_f7     = io_bus.instr[31:25];

  // State
  logic            r_alu_valid;
  logic [XLEN-1:0] r_alu_op1;
  logic [XLEN-1:0] r_alu_op2;
  logic [2:0]      r_alu_op_code;
  logic [RW-1:0]   r_alu_rd;
  logic            r_illegal;
  logic [NREG-1:0] r_pending;
  logic [XLEN-1:0] r_regs [NREG];

  // Decode
  logic       w_is_r;
  logic       w_is_i;
  logic       w_is_shift;
  logic       w_legal;
  logic [2:0] w_op_code;

  always_comb begin
    w_is_r     = (w_opcode == OPC_R);
    w_is_i     = (w_opcode == OPC_I);
    w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    w_op_code  = ALU_ADD;
    // f7 is only a selector for R-type; for OP-IMM it is imm[11:5] except on shifts
    w_legal    = w_is_i || (w_f7 == 7'b0);
    case (w_f3)
      3'b000: begin
        if (w_is_r && (w_f7 == F7_ALT)) begin
          w_op_code = ALU_SUB;
          w_legal   = 1'b1;
        end else begin
          w_op_code = ALU_ADD;
        end
      end
      3'b001: begin
        w_op_code = ALU_SLL;
        w_legal   = (w_f7 == 7'b0);
      end
      3'b010: w_op_code = ALU_SLT;
      3'b011: w_legal = 1'b0;
      3'b100: w_op_code = ALU_XOR;
      3'b101: begin
        w_op_code = ALU_SRL;
        w_legal   = (w_f7 == 7'b0);
      end
      3'b110: w_op_code = ALU_OR;
      default: w_op_code = ALU_AND;
    endcase
    if (!(w_is_r || w_is_i)) begin
      w_legal = 1'b0;
    end
  end

  // Scoreboard set/clear vectors and hazard view
  logic            w_wb_hit;
  logic [NREG-1:0] w_wb_clr;
  logic [NREG-1:0] w_iss_set;
  logic [NREG-1:0] w_pend_eff;
  logic            w_hazard;
  logic            w_instr_ready;
  logic            w_fire;
  logic            w_issue;

  assign w_wb_hit = io_bus.wb_valid && (io_bus.wb_rd != '0);
  assign w_wb_clr = w_wb_hit ? (NREG'(1) << io_bus.wb_rd) : '0;

`ifdef WB_BYPASS_EN
  assign w_pend_eff = r_pending & ~w_wb_clr;
`else
  assign w_pend_eff = r_pending;
`endif

  // Illegal words touch no register, so they never wait on the scoreboard
  assign w_hazard      = w_legal && (w_pend_eff[w_rs1] ||
                                     (w_is_r && w_pend_eff[w_rs2]) ||
                                     w_pend_eff[w_rd]);
  assign w_instr_ready = (!r_alu_valid || io_bus.alu_ready) && !w_hazard;
  assign w_fire        = io_bus.instr_valid && w_instr_ready;
  assign w_issue       = w_fire && w_legal;
  assign w_iss_set     = (w_issue && (w_rd != '0)) ? (NREG'(1) << w_rd) : '0;

  // Operand read; x0 always reads zero
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_op2;

  always_comb begin
    w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
`ifdef WB_BYPASS_EN
    if (w_wb_hit && (io_bus.wb_rd == w_rs1)) begin
      w_rs1_val = io_bus.wb_data;
    end
    if (w_wb_hit && (io_bus.wb_rd == w_rs2)) begin
      w_rs2_val = io_bus.wb_data;
    end
`endif
  end

  assign w_imm = w_is_shift ? XLEN'(io_bus.instr[24:20])
                            : {{(XLEN-IMM_W){io_bus.instr[31]}}, io_bus.instr[31:20]};
  assign w_op2 = w_is_r ? w_rs2_val : w_imm;

  // ALU handoff register; fields only move on a legal accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_valid   <= 1'b0;
      r_alu_op1     <= '0;
      r_alu_op2     <= '0;
      r_alu_op_code <= ALU_AND;
      r_alu_rd      <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_illegal <= w_fire && !w_legal;
      if (w_issue) begin
        r_alu_valid   <= 1'b1;
        r_alu_op1     <= w_rs1_val;
        r_alu_op2     <= w_op2;
        r_alu_op_code <= w_op_code;
        r_alu_rd      <= w_rd;
      end else if (io_bus.alu_ready) begin
        r_alu_valid <= 1'b0;
      end
    end
  end

  // Scoreboard: a same-cycle set overrides the writeback clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_wb_clr) | w_iss_set;
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_hit) begin
      r_regs[io_bus.wb_rd] <= io_bus.wb_data;
    end
  end

  assign io_bus.instr_ready = w_instr_ready;
  assign io_bus.alu_valid   = r_alu_valid;
  assign io_bus.alu_op1     = r_alu_op1;
  assign io_bus.alu_op2     = r_alu_op2;
  assign io_bus.alu_op_code = r_alu_op_code;
  assign io_bus.alu_rd      = r_alu_rd;
  assign io_bus.illegal     = r_illegal;

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Bench for rv32_alu_issue: directed scenarios then random traffic, all
// compared cycle by cycle against a table-driven instruction-level model.
module tb_rv32_alu_issue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32_alu_issue_if #(.XLEN(32)) bus ();

  rv32_alu_issue u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // RV32I match/mask table for the supported subset, with the ALU code each maps to
  localparam int unsigned NT = 15;
  localparam logic [31:0] MR = 32'hFE00707F;
  localparam logic [31:0] MI = 32'h0000707F;
  localparam logic [31:0] T_MATCH [NT] = '{
    32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00004033,
    32'h00005033, 32'h00006033, 32'h00007033, 32'h00000013, 32'h00001013,
    32'h00002013, 32'h00004013, 32'h00005013, 32'h00006013, 32'h00007013};
  localparam logic [31:0] T_MASK [NT] = '{
    MR, MR, MR, MR, MR, MR, MR, MR, MI, MR, MI, MI, MR, MI, MI};
  localparam logic [2:0] T_OPC [NT] = '{
    3'd4, 3'd5, 3'd6, 3'd3, 3'd2, 3'd7, 3'd1, 3'd0,
    3'd4, 3'd6, 3'd3, 3'd2, 3'd7, 3'd1, 3'd0};

  // Architectural model state
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_op1;
  logic [31:0] m_op2;
  logic [2:0]  m_opc;
  logic [4:0]  m_rd;
  bit          m_ill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_opc = '0; m_rd = '0; m_ill = 1'b0;
  endtask

  function automatic void m_decode(input logic [31:0] w, output bit legal, output logic [2:0] opc);
    legal = 1'b0;
    opc   = 3'd0;
    for (int i = 0; i < int'(NT); i++) begin
      if ((w & T_MASK[i]) == T_MATCH[i]) begin
        legal = 1'b1;
        opc   = T_OPC[i];
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd == r) return bus.wb_data;
`endif
    return m_regs[r];
  endfunction

  task automatic drive(input bit iv, input logic [31:0] w, input bit ar,
                       input bit wv, input logic [4:0] wrd, input logic [31:0] wd);
    bus.instr_valid = iv;
    bus.instr       = w;
    bus.alu_ready   = ar;
    bus.wb_valid    = wv;
    bus.wb_rd       = wrd;
    bus.wb_data     = wd;
  endtask

  task automatic chk_outs();
    chk("alu_valid",   32'(bus.alu_valid),   32'(m_valid));
    chk("alu_op1",     bus.alu_op1,          m_op1);
    chk("alu_op2",     bus.alu_op2,          m_op2);
    chk("alu_op_code", 32'(bus.alu_op_code), 32'(m_opc));
    chk("alu_rd",      32'(bus.alu_rd),      32'(m_rd));
    chk("illegal",     32'(bus.illegal),     32'(m_ill));
  endtask

  // One clock: check ready mid-cycle, advance the model, check registered outputs
  task automatic cyc();
    bit          legal, isr, hz, rdy, fire;
    logic [2:0]  opc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2;
    bit          pe [32];
    m_decode(bus.instr, legal, opc);
    isr = (bus.instr[6:0] == 7'h33);
    rs1 = bus.instr[19:15];
    rs2 = bus.instr[24:20];
    rd  = bus.instr[11:7];
    for (int i = 0; i < 32; i++) pe[i] = m_pend[i];
`ifdef WB_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd != 5'd0) pe[bus.wb_rd] = 1'b0;
`endif
    hz   = legal && (pe[rs1] || (isr && pe[rs2]) || pe[rd]);
    rdy  = (!m_valid || bus.alu_ready) && !hz;
    fire = bus.instr_valid && rdy;
    v1   = m_read(rs1);
    v2   = isr ? m_read(rs2) : 32'($signed(bus.instr[31:20]));
    #1;
    chk("instr_ready", 32'(bus.instr_ready), 32'(rdy));
    @(posedge clk);
    m_ill = fire && !legal;
    if (fire && legal) begin
      m_valid = 1'b1; m_op1 = v1; m_op2 = v2; m_opc = opc; m_rd = rd;
    end else if (bus.alu_ready) begin
      m_valid = 1'b0;
    end
    if (bus.wb_valid && bus.wb_rd != 5'd0) begin
      m_pend[bus.wb_rd] = 1'b0;
      m_regs[bus.wb_rd] = bus.wb_data;
    end
    if (fire && legal && rd != 5'd0) m_pend[rd] = 1'b1;
    #1;
    chk_outs();
  endtask

  function automatic logic [31:0] gen_instr();
    int unsigned t   = $urandom % 10;
    logic [4:0]  rd  = 5'($urandom % 8);
    logic [4:0]  rs1 = 5'($urandom % 8);
    logic [4:0]  rs2 = 5'($urandom % 8);
    logic [2:0]  f3  = 3'($urandom);
    logic [6:0]  f7;
    case ($urandom % 4)
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (t == 0) return $urandom;
    if (t < 5) return {f7, rs2, rs1, f3, rd, 7'h33};
    if (f3 == 3'b001 || f3 == 3'b101) return {f7, 5'($urandom), rs1, f3, rd, 7'h13};
    return {7'($urandom), 5'($urandom), rs1, f3, rd, 7'h13};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] pl [$];
    bit         wv;
    logic [4:0] wrd;

    // Reset state
    rst_n = 1'b0;
    drive(0, '0, 1, 0, '0, '0);
    m_reset();
    #12;
    chk_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Preload x1=5, x2=7 through writeback
    drive(0, '0, 1, 1, 5'd1, 32'd5); cyc();
    drive(0, '0, 1, 1, 5'd2, 32'd7); cyc();

    // ADD x3,x1,x2
    drive(1, 32'h002081B3, 1, 0, '0, '0); cyc();
    chk("add_valid", 32'(bus.alu_valid), 32'd1);
    chk("add_op1", bus.alu_op1, 32'd5);
    chk("add_op2", bus.alu_op2, 32'd7);
    chk("add_opc", 32'(bus.alu_op_code), 32'd4);
    chk("add_rd", 32'(bus.alu_rd), 32'd3);

    // ADDI x4,x0,-1
    drive(1, 32'hFFF00213, 1, 0, '0, '0); cyc();
    chk("addi_op1", bus.alu_op1, 32'd0);
    chk("addi_op2", bus.alu_op2, 32'hFFFFFFFF);

    // SUB x5,x1,x2 then SLLI x6,x1,31 back to back
    drive(1, 32'h402082B3, 1, 0, '0, '0); cyc();
    chk("sub_opc", 32'(bus.alu_op_code), 32'd5);
    drive(1, 32'h01F09313, 1, 0, '0, '0); cyc();
    chk("slli_opc", 32'(bus.alu_op_code), 32'd6);
    chk("slli_op2", bus.alu_op2, 32'd31);

    // RAW on x3: ADD x7,x3,x1 stalls until x3 is written back
    drive(1, 32'h001183B3, 1, 0, '0, '0); cyc();
    chk("raw_stall", 32'(bus.instr_ready), 32'd0);
    cyc();
    drive(1, 32'h001183B3, 1, 1, 5'd3, 32'd12); cyc();
`ifndef WB_BYPASS_EN
    chk("raw_wb_cycle_no_issue", 32'(bus.alu_valid), 32'd0);
    drive(1, 32'h001183B3, 1, 0, '0, '0); cyc();
`endif
    chk("raw_valid", 32'(bus.alu_valid), 32'd1);
    chk("raw_op1", bus.alu_op1, 32'd12);
    chk("raw_rd", 32'(bus.alu_rd), 32'd7);

    // Backpressure: ANDI x9,x1,3 waits three cycles behind the held ADD
    drive(1, 32'h0030F493, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) cyc();
    chk("bp_hold_rd", 32'(bus.alu_rd), 32'd7);
    chk("bp_hold_op1", bus.alu_op1, 32'd12);
    drive(1, 32'h0030F493, 1, 0, '0, '0); cyc();
    chk("bp_next_rd", 32'(bus.alu_rd), 32'd9);
    chk("bp_next_op2", bus.alu_op2, 32'd3);
    chk("bp_next_opc", 32'(bus.alu_op_code), 32'd0);

    // Illegal words: SRA and a load opcode
    drive(1, 32'h4020D1B3, 1, 0, '0, '0); cyc();
    chk("sra_illegal", 32'(bus.illegal), 32'd1);
    chk("sra_no_issue", 32'(bus.alu_valid), 32'd0);
    drive(1, 32'h00000003, 1, 0, '0, '0); cyc();
    chk("load_illegal", 32'(bus.illegal), 32'd1);
    drive(0, '0, 1, 0, '0, '0); cyc();
    chk("illegal_one_cycle", 32'(bus.illegal), 32'd0);

    // Reset while an instruction is held for the ALU
    drive(1, 32'h00100413, 0, 0, '0, '0); cyc();
    chk("pre_rst_valid", 32'(bus.alu_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.alu_valid), 32'd0);
    m_reset();
    drive(0, '0, 1, 0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", 32'(bus.alu_valid), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      pl = {};
      for (int i = 1; i < 32; i++) if (m_pend[i]) pl.push_back(5'(i));
      wv  = 1'b0;
      wrd = 5'd0;
      if (pl.size() > 0 && ($urandom % 2) == 0) begin
        wv  = 1'b1;
        wrd = pl[$urandom % pl.size()];
      end else if (($urandom % 8) == 0) begin
        wv  = 1'b1;
        wrd = 5'($urandom % 8);
      end
      drive(($urandom % 4) != 0, gen_instr(), ($urandom % 4) != 0, wv, wrd, $urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
